// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data memory for the core's load/store port. It takes one
//   request at a time over a valid/ready handshake and performs the RAM
//   access LATENCY cycles later. It then holds the response (read data plus
//   error flag) until the core takes it over a second valid/ready handshake.
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write/addr/wdata       store flag, byte address (word aligned), store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       load data (0 for stores/errors), misaligned or
//                              out-of-range flag
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_write;
  logic          c_err;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);

  // Fields used at the commit edge. With LATENCY==1 the commit happens on the
  // acceptance edge itself, so the live request fields are used instead of
  // the latched copy.
  always_comb begin
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    commit  = 1'b0;
    if (state == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      commit  = accept && (LATENCY == 1);
    end else if (state == WAIT) begin
      commit  = (cnt == CW'(1));
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
  assign c_idx = c_addr[AW+1:2];

  // RAM is never reset. The write is gated by reset so that a store still in
  // flight when reset arrives is never committed.
  always_ff @(posedge clk) begin
    if (commit && !reset && c_write && !c_err)
      mem[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (c_write || c_err) ? 32'h0 : mem[c_idx];
      end
      case (state)
        IDLE: if (accept) begin
          lat_write <= req_write;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          cnt       <= CW'(LATENCY - 1);
          state     <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: if (cnt == CW'(1)) begin
          cnt   <= '0;
          state <= RESP;
        end else begin
          cnt   <= cnt - CW'(1);
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=1)
// driven one after the other by directed transactions. A transaction-level
// model predicts every output each cycle; literal checks pin key results.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req_valid, req_write, resp_ready;
  logic [1:0]       req_ready, resp_valid, resp_err;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction is pending from its acceptance until its response is
  // taken; its result becomes visible LAT-1 edges after acceptance.
  logic [1:0]       m_pend = '0, m_vis = '0, m_err = '0, m_w = '0;
  logic [1:0][31:0] m_rd = '0, m_a = '0, m_d = '0;
  int               m_due [2];
  int               ncyc = 0;
  logic [31:0]      mm [2][64];

  always @(posedge clk or posedge rst[0] or posedge rst[1]) begin : mdl
    logic ce;
    ce = clk;  // reset is only ever raised while clk is low
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_pend[k] = 1'b0; m_vis[k] = 1'b0; m_rd[k] = '0; m_err[k] = 1'b0;
      end else if (ce) begin
        if (m_pend[k] && m_vis[k]) begin
          if (resp_ready[k]) m_pend[k] = 1'b0;
        end else if (!m_pend[k] && req_valid[k]) begin
          m_pend[k] = 1'b1; m_vis[k] = 1'b0;
          m_w[k] = req_write[k]; m_a[k] = req_addr[k]; m_d[k] = req_wdata[k];
          m_due[k] = ncyc + ((k == 0) ? 2 : 1) - 1;
        end
        if (m_pend[k] && !m_vis[k] && ncyc == m_due[k]) begin
          m_vis[k] = 1'b1;
          if (m_a[k][1:0] != 2'b00 || m_a[k][31:2] >= 30'd64) begin
            m_err[k] = 1'b1; m_rd[k] = '0;
          end else if (m_w[k]) begin
            mm[k][m_a[k][7:2]] = m_d[k]; m_err[k] = 1'b0; m_rd[k] = '0;
          end else begin
            m_rd[k] = mm[k][m_a[k][7:2]]; m_err[k] = 1'b0;
          end
        end
      end
    end
    if (ce) ncyc++;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("req_ready[%0d]", k), req_ready[k], !m_pend[k]);
      chk1($sformatf("resp_valid[%0d]", k), resp_valid[k], m_pend[k] && m_vis[k]);
      chk32($sformatf("resp_rdata[%0d]", k), resp_rdata[k], m_rd[k]);
      chk1($sformatf("resp_err[%0d]", k), resp_err[k], m_err[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
    n = 0;
    while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk1("accept_timeout", req_ready[k], 1'b1);
    @(negedge clk);
    if (hold == 0) req_valid[k] = 1'b0;
    // change fields after acceptance; the DUT must keep the sampled ones
    req_write[k] = ~w; req_addr[k] = ~a; req_wdata[k] = ~d;
    n = 1;
    while (!resp_valid[k] && n < 20) begin @(negedge clk); n++; end
    lat = n; rd = resp_rdata[k]; er = resp_err[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_valid", resp_valid[k], 1'b1);
      chk1("hold_no_accept", req_ready[k], 1'b0);
    end
    req_valid[k] = 1'b0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
  endtask

  task automatic reset_now_and_check(input int k);
    #1 rst[k] = 1'b1;
    #1;
    chk1("rst_req_ready", req_ready[k], 1'b1);
    chk1("rst_resp_valid", resp_valid[k], 1'b0);
    chk32("rst_resp_rdata", resp_rdata[k], 32'h0);
    chk1("rst_resp_err", resp_err[k], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  task automatic run(input int k);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          lexp;
    lexp = (k == 0) ? 2 : 1;

    xact(k, 1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk32("store_lat", 32'(lat), 32'(lexp));
    chk32("store_rdata", rd, 32'h0);
    chk1("store_err", er, 1'b0);
    xact(k, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk32("load_lat", 32'(lat), 32'(lexp));
    chk32("load_rdata", rd, 32'hDEADBEEF);
    chk1("load_err", er, 1'b0);

    // idle with rdata=DEADBEEF held; async reset must clear it at once
    @(negedge clk);
    reset_now_and_check(k);

    xact(k, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    chk32("hold_load_rdata", rd, 32'hDEADBEEF);

    xact(k, 1'b1, 32'h12, 32'h12345678, 0, rd, er, lat);
    chk1("misalign_err", er, 1'b1);
    chk32("misalign_rdata", rd, 32'h0);
    xact(k, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk32("after_misalign_rdata", rd, 32'hDEADBEEF);

    xact(k, 1'b0, 32'h100, 32'h0, 0, rd, er, lat);
    chk1("range_err", er, 1'b1);
    chk32("range_rdata", rd, 32'h0);
    xact(k, 1'b1, 32'hFC, 32'hCAFEF00D, 0, rd, er, lat);
    xact(k, 1'b0, 32'hFC, 32'h0, 0, rd, er, lat);
    chk1("top_word_err", er, 1'b0);
    chk32("top_word_rdata", rd, 32'hCAFEF00D);

    xact(k, 1'b1, 32'h20, 32'h11111111, 0, rd, er, lat);
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = 1'b1;
    req_addr[k] = 32'h20; req_wdata[k] = 32'h22222222;
    chk1("inflight_ready", req_ready[k], 1'b1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    reset_now_and_check(k);
    xact(k, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    // LATENCY=2: reset lands in WAIT, the second store is abandoned.
    // LATENCY=1: the store committed on its acceptance edge; reset only
    // drops the response.
    chk32("inflight_load", rd, (k == 0) ? 32'h11111111 : 32'h22222222);
  endtask

  initial begin
    rst = 2'b11;
    req_valid = '0; req_write = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    for (int k = 0; k < 2; k++) run(k);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
